// File: rtl/shield_pkg.sv
// Shared definitions for the shield bank: default geometry, the transparent
// colour key, the per-shield state record and a small span-test helper.
package shield_pkg;

  localparam int SHIELD_N_DEF        = 3;
  localparam int SHIELD_SIZE_W_DEF   = 6;
  localparam int SHIELD_HITS_MAX_DEF = 3;
  localparam int SHIELD_BLINK_DEF    = 60;

  // ROM colour treated as "no sprite pixel here"
  localparam logic [11:0] TRANSPARENT = 12'h000;

  // Field widths cover every legal HITS_MAX / BLINK_FRAMES setting
  localparam int DMG_W   = 8;
  localparam int BLINK_W = 16;

  typedef struct packed {
    logic [DMG_W-1:0]   dmg;
    logic [BLINK_W-1:0] blink;
  } shield_state_t;

  // Half-open interval test: lo <= pos < lo + side
  function automatic logic in_span(input int pos, input int lo, input int side);
    return (pos >= lo) && (pos < (lo + side));
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle passed along the draw chain.
//   vcount/hcount : 11-bit beam position
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit colour
// Modport "in" receives the stream from the previous stage, "out" drives the next.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-latency register pipeline with synchronous reset.
// Ports: clk, rst (sync, active-high), din (WIDTH), dout (din delayed CLK_DEL cycles).
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_r [CLK_DEL];

  // Shift register: stage 0 takes din, each later stage takes its predecessor
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CLK_DEL; k++) pipe_r[k] <= {WIDTH{1'b0}};
    end else begin
      pipe_r[0] <= din;
      for (int k = 1; k < CLK_DEL; k++) pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign dout = pipe_r[CLK_DEL-1];

endmodule

// File: rtl/shield_state.sv
// Damage / invulnerability tracker for one shield.
// Ports:
//   clk, rst     clock, sync active-high reset
//   start_game   low clears the shield to its fresh state every cycle
//   hit          hit pulse for this shield
//   tick         one-cycle frame-start pulse
//   frame        low bits of dmg, selects the sprite frame
//   destroyed    registered, dmg has reached HITS_MAX
//   hidden       registered, shield is in the dark half of its blink cycle
// Macro DRAW_SHIELD_BLINK_EN: when defined, the shield hides while blink!=0
// and blink[2]==1; otherwise it is drawn steadily through the window.
module shield_state
  import shield_pkg::*;
#(
  parameter int HITS_MAX     = SHIELD_HITS_MAX_DEF,
  parameter int BLINK_FRAMES = SHIELD_BLINK_DEF,
  parameter int FRAME_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic               hit,
  input  logic               tick,
  output logic [FRAME_W-1:0] frame,
  output logic               destroyed,
  output logic               hidden
);

  localparam logic [DMG_W-1:0]   HM = DMG_W'(HITS_MAX);
  localparam logic [BLINK_W-1:0] BF = BLINK_W'(BLINK_FRAMES);

  shield_state_t st_r;
  shield_state_t st_nxt_s;
  logic          accept_s;
  logic          hidden_nxt_s;
  logic          destroyed_r;
  logic          hidden_r;

  // Next-state rules: game-off clear, hit acceptance, blink countdown
  always_comb begin
    st_nxt_s = st_r;
    accept_s = 1'b0;
    if (!start_game) begin
      st_nxt_s.dmg   = {DMG_W{1'b0}};
      st_nxt_s.blink = {BLINK_W{1'b0}};
    end else begin
      accept_s = hit && (st_r.dmg < HM) && (st_r.blink == {BLINK_W{1'b0}});
      if (accept_s) begin
        // a reload beats a simultaneous frame tick
        st_nxt_s.dmg   = st_r.dmg + DMG_W'(1);
        st_nxt_s.blink = BF;
      end else if (tick && (st_r.blink != {BLINK_W{1'b0}})) begin
        st_nxt_s.blink = st_r.blink - BLINK_W'(1);
      end else begin
        st_nxt_s = st_r;
      end
    end
  end

  // Hidden flag derived from the blink value about to be stored
  always_comb begin
`ifdef DRAW_SHIELD_BLINK_EN
    hidden_nxt_s = (st_nxt_s.blink != {BLINK_W{1'b0}}) && st_nxt_s.blink[2];
`else
    hidden_nxt_s = 1'b0;
`endif
  end

  // State and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r.dmg    <= {DMG_W{1'b0}};
      st_r.blink  <= {BLINK_W{1'b0}};
      destroyed_r <= 1'b0;
      hidden_r    <= 1'b0;
    end else begin
      st_r        <= st_nxt_s;
      destroyed_r <= (st_nxt_s.dmg == HM);
      hidden_r    <= hidden_nxt_s;
    end
  end

  assign frame     = st_r.dmg[FRAME_W-1:0];
  assign destroyed = destroyed_r;
  assign hidden    = hidden_r;

endmodule

// File: rtl/draw_shield_bank.sv
// Overlays a row of N_SHIELDS damageable sprite shields onto the VGA stream.
// Ports:
//   clk, rst     pixel clock, sync active-high reset
//   start_game   game running; low holds every shield fresh
//   en           drawing enable (state keeps updating when low)
//   hit          per-shield hit pulses
//   rgb_pixel    sprite ROM data, valid one cycle after pixel_addr
//   pixel_addr   {frame, row, col} ROM address; holds when nothing is drawn
//   destroyed    per-shield destroyed flags (registered)
//   in / out     VGA stream in and out, 3 cycles of latency
// Pipeline: stage 1 decodes region/visibility and registers pixel_addr,
// stage 2 waits on the ROM, stage 3 muxes the colour into out.*.
// Macro DRAW_SHIELD_BLINK_EN enables hiding during the invulnerability window.
module draw_shield_bank
  import shield_pkg::*;
#(
  parameter int N_SHIELDS    = SHIELD_N_DEF,
  parameter int XPOS         = 300,
  parameter int XSTEP        = 160,
  parameter int YPOS         = 200,
  parameter int SIZE_W       = SHIELD_SIZE_W_DEF,
  parameter int HITS_MAX     = SHIELD_HITS_MAX_DEF,
  parameter int BLINK_FRAMES = SHIELD_BLINK_DEF,
  localparam int FRAME_W     = (HITS_MAX > 1) ? $clog2(HITS_MAX) : 1,
  localparam int ADDR_W      = FRAME_W + 2 * SIZE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_game,
  input  logic                 en,
  input  logic [N_SHIELDS-1:0] hit,
  input  logic [11:0]          rgb_pixel,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic [N_SHIELDS-1:0] destroyed,
  vga_if.in                    in,
  vga_if.out                   out
);

  localparam int SIDE  = 1 << SIZE_W;
  localparam int DLY_W = 11 + 11 + 4 + 12;

  logic               tick_s;
  logic [FRAME_W-1:0] frame_s [N_SHIELDS];
  logic [N_SHIELDS-1:0] hidden_s;
  logic               sel_s;
  logic [ADDR_W-1:0]  addr_nxt_s;
  logic               sel_r;
  logic               sel_d_r;
  logic [DLY_W-1:0]   dly_s;

  assign tick_s = (in.hcount == 11'd0) && (in.vcount == 11'd0);

  for (genvar g = 0; g < N_SHIELDS; g++) begin : g_shield
    shield_state #(
      .HITS_MAX    (HITS_MAX),
      .BLINK_FRAMES(BLINK_FRAMES),
      .FRAME_W     (FRAME_W)
    ) u_state (
      .clk       (clk),
      .rst       (rst),
      .start_game(start_game),
      .hit       (hit[g]),
      .tick      (tick_s),
      .frame     (frame_s[g]),
      .destroyed (destroyed[g]),
      .hidden    (hidden_s[g])
    );
  end

  // Stage 1 decode: first visible shield covering the pixel wins
  always_comb begin
    int x0_v;
    int row_v;
    int col_v;
    sel_s      = 1'b0;
    addr_nxt_s = pixel_addr;
    x0_v       = 0;
    row_v      = 0;
    col_v      = 0;
    for (int i = 0; i < N_SHIELDS; i++) begin
      x0_v  = XPOS + i * XSTEP;
      row_v = int'(in.vcount) - YPOS;
      col_v = int'(in.hcount) - x0_v;
      if (!sel_s && !in.hblnk && !in.vblnk && en && start_game &&
          !destroyed[i] && !hidden_s[i] &&
          in_span(int'(in.hcount), x0_v, SIDE) &&
          in_span(int'(in.vcount), YPOS, SIDE)) begin
        sel_s      = 1'b1;
        addr_nxt_s = {frame_s[i], SIZE_W'(row_v), SIZE_W'(col_v)};
      end else begin
        // lower index already claimed the pixel, or this shield is not drawn
        sel_s = sel_s;
      end
    end
  end

  // Stage 1/2 registers: ROM address and the draw flag travelling with it
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= {ADDR_W{1'b0}};
      sel_r      <= 1'b0;
      sel_d_r    <= 1'b0;
    end else begin
      pixel_addr <= addr_nxt_s;
      sel_r      <= sel_s;
      sel_d_r    <= sel_r;
    end
  end

  delay #(
    .WIDTH  (DLY_W),
    .CLK_DEL(2)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din ({in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb}),
    .dout(dly_s)
  );

  // Stage 3: registered outputs, sprite colour unless the ROM returns the key
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= 11'd0;
      out.vcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'h000;
    end else begin
      out.hcount <= dly_s[37:27];
      out.vcount <= dly_s[26:16];
      out.hsync  <= dly_s[15];
      out.vsync  <= dly_s[14];
      out.hblnk  <= dly_s[13];
      out.vblnk  <= dly_s[12];
      out.rgb    <= (sel_d_r && (rgb_pixel != TRANSPARENT)) ? rgb_pixel : dly_s[11:0];
    end
  end

endmodule

// File: tb/tb_draw_shield_bank.sv
// Self-checking bench for draw_shield_bank on a shrunken video frame.
// A behavioural model tracks each shield's damage and blink counts and
// predicts every output pixel three cycles ahead.
module tb_draw_shield_bank;
  localparam int P_N     = 3;
  localparam int P_XPOS  = 10;
  localparam int P_XSTEP = 6;
  localparam int P_YPOS  = 4;
  localparam int P_SW    = 3;
  localparam int P_HM    = 3;
  localparam int P_BF    = 6;
  localparam int SIDE    = 8;
  localparam int H_TOT   = 40;
  localparam int H_ACT   = 32;
  localparam int V_TOT   = 16;
  localparam int V_ACT   = 12;
  localparam int FRAME   = H_TOT * V_TOT;
  localparam int AW      = 2 + 2 * P_SW;

`ifdef DRAW_SHIELD_BLINK_EN
  localparam bit BLINK_HIDES = 1'b1;
`else
  localparam bit BLINK_HIDES = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_game = 1'b0;
  logic           en = 1'b1;
  logic [P_N-1:0] hit = '0;
  logic [11:0]    rgb_pixel = 12'h000;
  logic [AW-1:0]  pixel_addr;
  logic [P_N-1:0] destroyed;

  vga_if vin ();
  vga_if vout ();

  draw_shield_bank #(
    .N_SHIELDS(P_N), .XPOS(P_XPOS), .XSTEP(P_XSTEP), .YPOS(P_YPOS),
    .SIZE_W(P_SW), .HITS_MAX(P_HM), .BLINK_FRAMES(P_BF)
  ) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .en(en), .hit(hit),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr), .destroyed(destroyed),
    .in(vin), .out(vout)
  );

  always #5 clk = ~clk;

  // Sprite ROM content: a few addresses carry the transparent key
  function automatic logic [11:0] rom_f(input logic [AW-1:0] a);
    logic [11:0] v;
    if (a[1:0] == 2'b11 && a[4]) return 12'h000;
    v = {a[7:6], 2'b00, a[5:0], 2'b01} ^ 12'h3C4;
    if (v == 12'h000) v = 12'h001;
    return v;
  endfunction

  always @(posedge clk) rgb_pixel <= rom_f(pixel_addr);

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          hc = 0;
  int          vc = 0;
  int          m_dmg   [P_N];
  int          m_blink [P_N];
  int          m_addr = 0;
  logic [25:0] pipe_t [3];
  logic [11:0] pipe_r [3];

  function automatic bit is_hidden(input int b);
    return BLINK_HIDES && (b != 0) && (((b / 4) % 2) == 1);
  endfunction

  task automatic step(input logic [P_N-1:0] hit_v);
    int          sel;
    int          addr;
    logic [11:0] rin;
    logic [11:0] r_exp;
    logic [25:0] t_exp;
    logic [P_N-1:0] dmask;
    bit          tick;
    bit          blank;
    rin         = 12'($urandom);
    vin.hcount  = 11'(hc);
    vin.vcount  = 11'(vc);
    vin.hblnk   = (hc >= H_ACT);
    vin.vblnk   = (vc >= V_ACT);
    vin.hsync   = (hc >= 34 && hc < 37);
    vin.vsync   = (vc == 13);
    vin.rgb     = rin;
    hit         = hit_v;
    tick  = (hc == 0) && (vc == 0);
    blank = (hc >= H_ACT) || (vc >= V_ACT);
    sel   = -1;
    addr  = 0;
    for (int i = 0; i < P_N; i++) begin
      int x0;
      bit cov;
      bit vis;
      x0  = P_XPOS + i * P_XSTEP;
      cov = (hc >= x0) && (hc < x0 + SIDE) && (vc >= P_YPOS) && (vc < P_YPOS + SIDE);
      vis = en && start_game && (m_dmg[i] < P_HM) && !is_hidden(m_blink[i]);
      if (sel < 0 && cov && vis && !blank) begin
        sel  = i;
        addr = m_dmg[i] * SIDE * SIDE + (vc - P_YPOS) * SIDE + (hc - x0);
      end
    end
    r_exp = rin;
    if (sel >= 0 && rom_f(AW'(addr)) != 12'h000) r_exp = rom_f(AW'(addr));
    t_exp = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin pipe_t[k] = '0; pipe_r[k] = '0; end
      m_addr = 0;
      for (int i = 0; i < P_N; i++) begin m_dmg[i] = 0; m_blink[i] = 0; end
    end else begin
      pipe_t[2] = pipe_t[1]; pipe_t[1] = pipe_t[0]; pipe_t[0] = t_exp;
      pipe_r[2] = pipe_r[1]; pipe_r[1] = pipe_r[0]; pipe_r[0] = r_exp;
      if (sel >= 0) m_addr = addr;
      for (int i = 0; i < P_N; i++) begin
        if (!start_game) begin
          m_dmg[i] = 0; m_blink[i] = 0;
        end else if (hit_v[i] && m_dmg[i] < P_HM && m_blink[i] == 0) begin
          m_dmg[i]++; m_blink[i] = P_BF;
        end else if (tick && m_blink[i] > 0) begin
          m_blink[i]--;
        end
      end
    end
    #1;
    for (int i = 0; i < P_N; i++) dmask[i] = (m_dmg[i] == P_HM);
    check("timing", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
          64'(pipe_t[2]));
    check("rgb", 64'(vout.rgb), 64'(pipe_r[2]));
    check("pixel_addr", 64'(pixel_addr), 64'(m_addr));
    check("destroyed", 64'(destroyed), 64'(dmask));
    hc++;
    if (hc == H_TOT) begin hc = 0; vc = (vc + 1) % V_TOT; end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step('0);
  endtask

  task automatic wait_to(input int x, input int y);
    for (int c = 0; c < FRAME && !(hc == x && vc == y); c++) step('0);
  endtask

  initial begin
    for (int i = 0; i < P_N; i++) begin m_dmg[i] = 0; m_blink[i] = 0; end
    for (int k = 0; k < 3; k++) begin pipe_t[k] = '0; pipe_r[k] = '0; end
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    rst = 1'b1;
    run(3);
    check("reset_rgb", 64'(vout.rgb), 64'h0);
    check("reset_addr", 64'(pixel_addr), 64'h0);
    rst = 1'b0;
    start_game = 1'b1;
    run(2 * FRAME);

    // shield 1: accepted, ignored inside the window, accepted after it
    wait_to(20, 2);
    step(3'b010);
    run(3 * FRAME);
    step(3'b010);
    run(7 * FRAME);
    step(3'b010);

    // shield 0: destroy with three spaced hits, then one extra ignored hit
    for (int h = 0; h < 3; h++) begin
      run(7 * FRAME);
      step(3'b001);
    end
    check("destroyed_3hits", 64'(destroyed), 64'h1);
    run(3 * FRAME);
    step(3'b001);
    run(FRAME);

    // game off clears everything; then simultaneous hits on a frame tick
    start_game = 1'b0;
    step('0);
    check("destroyed_clear", 64'(destroyed), 64'h0);
    run(20);
    start_game = 1'b1;
    wait_to(0, 0);
    step(3'b111);
    run(8 * FRAME);

    // randomized phase
    for (int c = 0; c < 12 * FRAME; c++) begin
      logic [P_N-1:0] h;
      for (int i = 0; i < P_N; i++) h[i] = ($urandom_range(0, 299) == 0);
      if ((c % 97) == 0) en = ($urandom_range(0, 3) != 0);
      if ((c % 2500) == 1200) start_game = 1'b0;
      if ((c % 2500) == 1215) start_game = 1'b1;
      step(h);
    end

    // reset in the middle of a line
    en = 1'b1;
    start_game = 1'b1;
    wait_to(14, 6);
    rst = 1'b1;
    step('0);
    check("rst_mid_rgb", 64'(vout.rgb), 64'h0);
    check("rst_mid_hcount", 64'(vout.hcount), 64'h0);
    rst = 1'b0;
    run(2 * FRAME);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
